// File: rtl/alu_issue_capture.sv
// Registers operation packets onto the combinational ALU inputs, holds them for
// SETTLE cycles, then captures the ALU outputs into a 2-entry response buffer.
module alu_issue_capture #(
    parameter int XLEN   = 64,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [XLEN-1:0] ReqA,
    input  logic [XLEN-1:0] ReqB,
    input  logic [34:0]     ReqCtl,
    input  logic [3:0]      ReqTag,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic            W64,
    output logic            UW64,
    output logic            SubArith,
    output logic [2:0]      ALUSelect,
    output logic [3:0]      BSelect,
    output logic [3:0]      ZBBSelect,
    output logic [2:0]      Funct3,
    output logic [6:0]      Funct7,
    output logic [4:0]      Rs2E,
    output logic [2:0]      BALUControl,
    output logic            BMUActive,
    output logic [1:0]      CZero,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] Sum,
    output logic            RspValid,
    input  logic            RspReady,
    output logic [XLEN-1:0] RspResult,
    output logic [XLEN-1:0] RspSum,
    output logic [3:0]      RspTag
);

    typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [34:0]     ctl_q;
    logic [3:0]      tag_q;

    logic [XLEN-1:0] res_q [2];
    logic [XLEN-1:0] sum_q [2];
    logic [3:0]      btag_q [2];
    logic            rd_ptr, wr_ptr;
    logic [1:0]      count;

    logic            acc, push, pop;

    assign ReqReady = (state == ST_IDLE) && (count < 2'd2);
    assign acc      = ReqValid && ReqReady;
    assign push     = (state == ST_SETTLE) && (cnt == 4'd1);
    assign pop      = RspValid && RspReady;

    assign {W64, UW64, SubArith, ALUSelect, BSelect, ZBBSelect, Funct3, Funct7,
            Rs2E, BALUControl, BMUActive, CZero} = ctl_q;

    // Operands and controls stay put after capture so the ALU inputs only toggle on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            A     <= '0;
            B     <= '0;
            ctl_q <= '0;
            tag_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (acc) begin
                    A     <= ReqA;
                    B     <= ReqB;
                    ctl_q <= ReqCtl;
                    tag_q <= ReqTag;
                    cnt   <= 4'(SETTLE);
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    cnt <= cnt - 4'd1;
                    if (push) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
            for (int i = 0; i < 2; i++) begin
                res_q[i]  <= '0;
                sum_q[i]  <= '0;
                btag_q[i] <= '0;
            end
        end else begin
            if (push) begin
                res_q[wr_ptr]  <= ALUResult;
                sum_q[wr_ptr]  <= Sum;
                btag_q[wr_ptr] <= tag_q;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign RspValid  = (count != 2'd0);
    assign RspResult = res_q[rd_ptr];
    assign RspSum    = sum_q[rd_ptr];
    assign RspTag    = btag_q[rd_ptr];

endmodule

// File: tb/tb_alu_issue_capture.sv
// Directed bench for alu_issue_capture: vector table plus multi-cycle sequences,
// with a tiny behavioural ALU closing the loop from A/B/controls to ALUResult/Sum.
module tb_alu_issue_capture;
    localparam int XLEN = 64;
    localparam int S    = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ReqValid, ReqReady, RspValid, RspReady;
    logic [XLEN-1:0] ReqA, ReqB, A, B, ALUResult, Sum, RspResult, RspSum;
    logic [34:0]     ReqCtl;
    logic [3:0]      ReqTag, RspTag;
    logic            W64, UW64, SubArith, BMUActive;
    logic [2:0]      ALUSelect, Funct3, BALUControl;
    logic [3:0]      BSelect, ZBBSelect;
    logic [6:0]      Funct7;
    logic [4:0]      Rs2E;
    logic [1:0]      CZero;

    alu_issue_capture #(.XLEN(XLEN), .SETTLE(S)) dut (
        .clk(clk), .reset_n(reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqA(ReqA), .ReqB(ReqB), .ReqCtl(ReqCtl), .ReqTag(ReqTag), .A(A), .B(B),
        .W64(W64), .UW64(UW64), .SubArith(SubArith), .ALUSelect(ALUSelect),
        .BSelect(BSelect), .ZBBSelect(ZBBSelect), .Funct3(Funct3), .Funct7(Funct7),
        .Rs2E(Rs2E), .BALUControl(BALUControl), .BMUActive(BMUActive), .CZero(CZero),
        .ALUResult(ALUResult), .Sum(Sum), .RspValid(RspValid), .RspReady(RspReady),
        .RspResult(RspResult), .RspSum(RspSum), .RspTag(RspTag)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 sum/diff, 1 and, 2 or, else xor.
    always_comb begin
        Sum = SubArith ? A - B : A + B;
        case (ALUSelect)
            3'd0:    ALUResult = Sum;
            3'd1:    ALUResult = A & B;
            3'd2:    ALUResult = A | B;
            default: ALUResult = A ^ B;
        endcase
    end

    int checks = 0, failures = 0;
    int cyc = 0, acc_cnt = 0;
    int acc_cyc[$];
    logic [3:0]      pop_tag[$];
    logic [XLEN-1:0] pop_sum[$];

    always @(posedge clk) begin
        if (reset_n && ReqValid && ReqReady) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
        end
        if (reset_n && RspValid && RspReady) begin
            pop_tag.push_back(RspTag);
            pop_sum.push_back(RspSum);
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [34:0] ctl);
        int start;
        bit ok;
        start = acc_cnt;
        ok = 0;
        ReqValid = 1'b1; ReqTag = tag; ReqA = a; ReqB = b; ReqCtl = ctl;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (acc_cnt > start) begin ok = 1; break; end
        end
        ReqValid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    typedef struct {
        logic [63:0] a, b;
        logic [34:0] ctl;
        logic [3:0]  tag;
        logic [63:0] res, sum;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64'd5, 64'd7, 35'h0, 4'd3, 64'd12, 64'd12};
        vecs[1] = '{64'd3, 64'd5, 35'h1_0000_0000, 4'd6,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{64'hF0F0, 64'hFF00, 35'h0_2000_0000, 4'd7, 64'hF000, 64'h1_EFF0};
        vecs[3] = '{64'h0F, 64'hF0, 35'h0_4000_0000, 4'd8, 64'hFF, 64'hFF};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 35'h0, 4'd15, 64'd0, 64'd0};
        vecs[5] = '{64'h10, 64'h3, 35'h5_5555_5555, 4'd11, 64'h13, 64'hD};

        reset_n = 1'b0; ReqValid = 1'b0; RspReady = 1'b1;
        ReqA = '0; ReqB = '0; ReqCtl = '0; ReqTag = '0;
        #12;
        chk("rst_reqready", ReqReady, 1);
        chk("rst_rspvalid", RspValid, 0);
        chk("rst_a", A, 0);
        chk("rst_rsp_result", RspResult, 0);
        chk("rst_ctl", {W64, UW64, SubArith, ALUSelect, BSelect, ZBBSelect, Funct3,
                        Funct7, Rs2E, BALUControl, BMUActive, CZero}, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        // Table: latency, operand hold, control mapping and results.
        foreach (vecs[v]) begin
            int lat;
            lat = -1;
            issue(vecs[v].tag, vecs[v].a, vecs[v].b, vecs[v].ctl);
            chk("vec_reqready_low", ReqReady, 0);
            chk("vec_ctl", {W64, UW64, SubArith, ALUSelect, BSelect, ZBBSelect, Funct3,
                            Funct7, Rs2E, BALUControl, BMUActive, CZero}, vecs[v].ctl);
            for (int i = 1; i <= S + 3; i++) begin
                @(negedge clk);
                if (RspValid) begin lat = i; break; end
                chk("vec_a_hold", A, vecs[v].a);
                chk("vec_b_hold", B, vecs[v].b);
            end
            chk("vec_latency", lat, S);
            chk("vec_result", RspResult, vecs[v].res);
            chk("vec_sum", RspSum, vecs[v].sum);
            chk("vec_tag", RspTag, vecs[v].tag);
            chk("vec_reqready_back", ReqReady, 1);
            @(negedge clk);
            chk("vec_popped", RspValid, 0);
        end

        // Reset mid-settle discards the in-flight op.
        issue(4'd9, 64'd1, 64'd2, 35'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_rspvalid", RspValid, 0);
        chk("midrst_reqready", ReqReady, 1);
        chk("midrst_a", A, 0);
        chk("midrst_b", B, 0);
        @(negedge clk); reset_n = 1'b1;
        pop_tag.delete(); pop_sum.delete();
        repeat (S + 3) @(negedge clk);
        chk("midrst_no_stale", RspValid, 0);
        chk("midrst_no_pop", pop_tag.size(), 0);

        // Backpressure: two entries fill the buffer, third request waits.
        RspReady = 1'b0;
        pop_tag.delete(); pop_sum.delete();
        issue(4'd1, 64'd1, 64'd1, 35'h0);
        issue(4'd2, 64'd2, 64'd2, 35'h0);
        begin
            int base;
            base = acc_cnt;
            ReqValid = 1'b1; ReqTag = 4'd3; ReqA = 64'd3; ReqB = 64'd3; ReqCtl = '0;
            repeat (2 * (S + 1) + 2) @(negedge clk);
            chk("bp_full_reqready", ReqReady, 0);
            chk("bp_no_accept", acc_cnt - base, 0);
            chk("bp_head_tag", RspTag, 1);
            chk("bp_head_sum", RspSum, 2);
            RspReady = 1'b1;
            for (int i = 0; i < 40 && acc_cnt == base; i++) @(negedge clk);
            ReqValid = 1'b0;
            for (int i = 0; i < 40 && pop_tag.size() < 3; i++) @(negedge clk);
            chk("bp_pop_count", pop_tag.size(), 3);
            if (pop_tag.size() == 3) begin
                chk("bp_order0", pop_tag[0], 1);
                chk("bp_order1", pop_tag[1], 2);
                chk("bp_order2", pop_tag[2], 3);
                chk("bp_sum2", pop_sum[2], 6);
            end
        end

        // Capture and pop on the same edge keeps count at one.
        RspReady = 1'b0;
        issue(4'd4, 64'd4, 64'd4, 35'h0);
        repeat (S) @(negedge clk);
        chk("pp_one_entry", RspValid, 1);
        issue(4'd5, 64'd5, 64'd5, 35'h0);
        repeat (S - 1) @(negedge clk);
        RspReady = 1'b1;
        @(negedge clk);
        chk("pp_valid", RspValid, 1);
        chk("pp_new_head", RspTag, 5);
        chk("pp_new_sum", RspSum, 10);
        chk("pp_reqready", ReqReady, 1);
        @(negedge clk);
        chk("pp_drained", RspValid, 0);

        // Streaming with ReqValid held high.
        begin
            int base;
            base = acc_cnt;
            acc_cyc.delete(); pop_tag.delete(); pop_sum.delete();
            RspReady = 1'b1;
            for (int c = 0; c < 100; c++) begin
                if (acc_cnt - base < 6) begin
                    ReqValid = 1'b1;
                    ReqTag = 4'(acc_cnt - base + 1);
                    ReqA = 64'(acc_cnt - base + 1);
                    ReqB = 64'(acc_cnt - base + 1);
                    ReqCtl = '0;
                end else ReqValid = 1'b0;
                @(negedge clk);
                if (pop_tag.size() >= 6) break;
            end
            ReqValid = 1'b0;
            chk("st_pops", pop_tag.size(), 6);
            chk("st_accepts", acc_cyc.size(), 6);
            if (acc_cyc.size() == 6)
                for (int i = 1; i < 6; i++) chk("st_spacing", acc_cyc[i] - acc_cyc[i-1], S + 1);
            if (pop_tag.size() == 6)
                for (int i = 0; i < 6; i++) begin
                    chk("st_tag", pop_tag[i], i + 1);
                    chk("st_sum", pop_sum[i], 2 * (i + 1));
                end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
